pipelined_adder: RTL and testbench

- Parametrised successor to the combinational 32-bit adder: WIDTH-bit add/subtract split into STAGES carry-propagating slices, one slice per pipeline stage.
- Valid/ready handshake on both sides with full backpressure; reports carry-out and signed overflow.
- Sits in the datapath wherever a 32-bit ripple adder limits clock period.

---
 rtl/adder_pkg.sv | 9 +
 rtl/pipelined_adder_if.sv | 16 +
 rtl/adder_slice.sv | 12 +
 rtl/pipelined_adder.sv | 101 ++++++++++
 tb/tb_pipelined_adder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults, operation encoding and signed-overflow helper for the pipelined adder.
package adder_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STAGES = 4;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} add_op_t;
  function automatic logic signed_ovf(input logic sign_a, input logic sign_b, input logic msb);
    return (sign_a == sign_b) && (msb != sign_a);
  endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result valid-ready bundle; master drives operands, slave returns results.
interface pipelined_adder_if import adder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid, in_ready, cin, sub;
  logic             out_valid, out_ready, cout, overflow;
  logic [WIDTH-1:0] a, b, sum;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/adder_slice.sv
// adder_slice: combinational WIDTH-bit a+b+ci with carry out.
module adder_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o
);
  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, ci_i};
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract, one SLICE-bit carry slice per stage, valid/ready with full backpressure.
module pipelined_adder import adder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);
  localparam int SLICE = WIDTH / STAGES;
  if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end
  add_op_t          op;
  logic [WIDTH-1:0] b_eff;
  logic             chain;
  logic [WIDTH-1:0] a_s [STAGES];
  logic [WIDTH-1:0] b_s [STAGES];
  logic [WIDTH-1:0] sum_s [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [SLICE-1:0] s_w [STAGES];
  logic             c_w [STAGES];
  logic [STAGES-1:0] v_s, co_s, sa_s, sb_s, rdy;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [STAGES-1:0] vld_q, co_q, sa_q, sb_q;
  assign op = add_op_t'(bus.sub);
  assign b_eff = (op == OP_SUB) ? ~bus.b : bus.b;
  // Index k of each *_s array is what stage k consumes: the input port for k=0, stage k-1 otherwise.
  always_comb begin
    a_s[0] = bus.a;
    b_s[0] = b_eff;
    sum_s[0] = '0;
    v_s[0] = bus.in_valid;
    co_s[0] = (op == OP_SUB) || bus.cin;
    sa_s[0] = bus.a[WIDTH-1];
    sb_s[0] = b_eff[WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      a_s[k] = a_q[k-1];
      b_s[k] = b_q[k-1];
      sum_s[k] = sum_q[k-1];
      v_s[k] = vld_q[k-1];
      co_s[k] = co_q[k-1];
      sa_s[k] = sa_q[k-1];
      sb_s[k] = sb_q[k-1];
    end
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(.WIDTH(SLICE)) u_slice (
      .a_i  (a_s[k][k*SLICE +: SLICE]),
      .b_i  (b_s[k][k*SLICE +: SLICE]),
      .ci_i (co_s[k]),
      .s_o  (s_w[k]),
      .co_o (c_w[k])
    );
  end
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k] = sum_s[k];
      sum_d[k][k*SLICE +: SLICE] = s_w[k];
    end
  end
  // Ready ripples back from the output so empty stages keep absorbing beats during a stall.
  always_comb begin
    chain = bus.out_ready;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain = !vld_q[k] || chain;
      rdy[k] = chain;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      co_q <= '0;
      sa_q <= '0;
      sb_q <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      sum_q <= '{default: '0};
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) vld_q[k] <= v_s[k];
        if (rdy[k] && v_s[k]) begin
          a_q[k] <= a_s[k];
          b_q[k] <= b_s[k];
          sum_q[k] <= sum_d[k];
          co_q[k] <= c_w[k];
          sa_q[k] <= sa_s[k];
          sb_q[k] <= sb_s[k];
        end
      end
    end
  end
  assign bus.in_ready = rdy[0];
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum = sum_q[STAGES-1];
  assign bus.cout = co_q[STAGES-1];
  assign bus.overflow = signed_ovf(sa_q[STAGES-1], sb_q[STAGES-1], sum_q[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks on the 32/4 adder plus scoreboarded random runs on 32/1 and 16/2 builds.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pipelined_adder_if #(.WIDTH(32)) bus0 ();
  pipelined_adder_if #(.WIDTH(32)) bus1 ();
  pipelined_adder_if #(.WIDTH(16)) bus2 ();
  pipelined_adder #(.WIDTH(32), .STAGES(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pipelined_adder #(.WIDTH(32), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipelined_adder #(.WIDTH(16), .STAGES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    bus0.in_valid = 1'b1;
    bus0.a = a;
    bus0.b = b;
    bus0.cin = cin;
    bus0.sub = sub;
    #1;
    chk("accept", 64'(bus0.in_ready), 64'(1));
    step();
  endtask

  task automatic out0(input string tag, input logic [31:0] s, input logic c, input logic o);
    chk({tag, "_valid"}, 64'(bus0.out_valid), 64'(1));
    chk({tag, "_sum"}, 64'(bus0.sum), 64'(s));
    chk({tag, "_cout"}, 64'(bus0.cout), 64'(c));
    chk({tag, "_ovf"}, 64'(bus0.overflow), 64'(o));
  endtask

  // Reference result {overflow, cout, sum} computed with wide signed/unsigned arithmetic.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint ua, ub, sa, sb, r, sr, half;
    logic [31:0] s;
    half = longint'(1) << (w - 1);
    ua = longint'(a);
    ub = longint'(b);
    sa = a[w-1] ? ua - 2 * half : ua;
    sb = b[w-1] ? ub - 2 * half : ub;
    r = sub ? ua - ub : ua + ub + longint'(cin);
    sr = sub ? sa - sb : sa + sb + longint'(cin);
    s = 32'(r & (2 * half - 1));
    return {(sr >= half) || (sr < -half), sub ? (ua >= ub) : (r >= 2 * half), s};
  endfunction

  initial begin
    logic acc;
    int nxt;
    logic [31:0] got[$];
    logic [33:0] q1[$];
    logic [33:0] q2[$];
    logic [33:0] exp;
    {bus0.in_valid, bus0.a, bus0.b, bus0.cin, bus0.sub} = '0;
    {bus1.in_valid, bus1.a, bus1.b, bus1.cin, bus1.sub} = '0;
    {bus2.in_valid, bus2.a, bus2.b, bus2.cin, bus2.sub} = '0;
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    bus2.out_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    chk("rst_valid", 64'(bus0.out_valid), 64'(0));
    chk("rst_ready", 64'(bus0.in_ready), 64'(1));
    chk("rst_sum", 64'(bus0.sum), 64'(0));
    chk("rst_cout", 64'(bus0.cout), 64'(0));
    chk("rst_ovf", 64'(bus0.overflow), 64'(0));

    send0(32'd8, 32'd9, 1'b0, 1'b0);
    send0(32'd11, 32'd1, 1'b0, 1'b0);
    send0(32'd11, 32'd15, 1'b0, 1'b0);
    bus0.in_valid = 1'b0;
    chk("lat_early", 64'(bus0.out_valid), 64'(0));
    step();
    out0("b2b_a", 32'd17, 1'b0, 1'b0);
    step();
    out0("b2b_b", 32'd12, 1'b0, 1'b0);
    step();
    out0("b2b_c", 32'd26, 1'b0, 1'b0);
    step();
    chk("b2b_end", 64'(bus0.out_valid), 64'(0));

    send0(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    send0(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    bus0.in_valid = 1'b0;
    step();
    step();
    out0("wrap", 32'h0, 1'b1, 1'b0);
    step();
    out0("add_ovf", 32'h8000_0000, 1'b0, 1'b1);

    send0(32'd5, 32'd7, 1'b1, 1'b1);
    send0(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    bus0.in_valid = 1'b0;
    step();
    step();
    out0("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0);
    step();
    out0("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
    step();

    nxt = 1;
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 40 && got.size() < 6; i++) begin
      if (i == 10) bus0.out_ready = 1'b1;
      bus0.in_valid = (nxt <= 6);
      bus0.a = 32'(nxt);
      bus0.b = 32'd1;
      bus0.cin = 1'b0;
      bus0.sub = 1'b0;
      #1;
      acc = bus0.in_valid && bus0.in_ready;
      if (i >= 4 && i < 10) begin
        chk("bp_hold_valid", 64'(bus0.out_valid), 64'(1));
        chk("bp_hold_sum", 64'(bus0.sum), 64'(2));
      end
      if (i == 9) begin
        chk("bp_accepts", 64'(nxt - 1), 64'(4));
        chk("bp_in_ready", 64'(bus0.in_ready), 64'(0));
      end
      if (bus0.out_valid && bus0.out_ready) got.push_back(bus0.sum);
      step();
      if (acc) nxt++;
    end
    bus0.in_valid = 1'b0;
    chk("bp_count", 64'(got.size()), 64'(6));
    for (int k = 0; k < got.size(); k++) chk("bp_order", 64'(got[k]), 64'(k + 2));

    send0(32'd100, 32'd1, 1'b0, 1'b0);
    send0(32'd200, 32'd2, 1'b0, 1'b0);
    send0(32'd300, 32'd3, 1'b0, 1'b0);
    bus0.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(bus0.out_valid), 64'(0));
    chk("mid_rst_ready", 64'(bus0.in_ready), 64'(1));
    chk("mid_rst_sum", 64'(bus0.sum), 64'(0));
    chk("mid_rst_cout", 64'(bus0.cout), 64'(0));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_rst_flush", 64'(bus0.out_valid), 64'(0));
    end
    send0(32'd2, 32'd3, 1'b0, 1'b0);
    bus0.in_valid = 1'b0;
    step();
    step();
    chk("post_rst_early", 64'(bus0.out_valid), 64'(0));
    step();
    out0("post_rst", 32'd5, 1'b0, 1'b0);

    bus1.in_valid = 1'b1;
    bus1.a = 32'd2;
    bus1.b = 32'd3;
    #1;
    chk("s1_idle", 64'(bus1.out_valid), 64'(0));
    step();
    bus1.in_valid = 1'b0;
    chk("s1_lat_valid", 64'(bus1.out_valid), 64'(1));
    chk("s1_lat_sum", 64'(bus1.sum), 64'(5));
    step();

    for (int i = 0; i < 300; i++) begin
      bus1.in_valid = (i < 280) && ($urandom_range(0, 3) != 0);
      bus1.a = $urandom;
      bus1.b = $urandom;
      bus1.cin = 1'($urandom_range(0, 1));
      bus1.sub = 1'($urandom_range(0, 1));
      bus1.out_ready = (i >= 280) || ($urandom_range(0, 3) != 0);
      bus2.in_valid = (i < 280) && ($urandom_range(0, 3) != 0);
      bus2.a = 16'($urandom);
      bus2.b = 16'($urandom);
      bus2.cin = 1'($urandom_range(0, 1));
      bus2.sub = 1'($urandom_range(0, 1));
      bus2.out_ready = (i >= 280) || ($urandom_range(0, 3) != 0);
      #1;
      if (bus1.in_valid && bus1.in_ready)
        q1.push_back(model(32, bus1.a, bus1.b, bus1.cin, bus1.sub));
      if (bus2.in_valid && bus2.in_ready)
        q2.push_back(model(16, {16'h0, bus2.a}, {16'h0, bus2.b}, bus2.cin, bus2.sub));
      if (bus1.out_valid && bus1.out_ready) begin
        exp = (q1.size() > 0) ? q1.pop_front() : 'x;
        chk("sweep_w32_s1", 64'({bus1.overflow, bus1.cout, bus1.sum}), 64'(exp));
      end
      if (bus2.out_valid && bus2.out_ready) begin
        exp = (q2.size() > 0) ? q2.pop_front() : 'x;
        chk("sweep_w16_s2", 64'({bus2.overflow, bus2.cout, 16'h0, bus2.sum}), 64'(exp));
      end
      step();
    end
    chk("sweep_w32_s1_drain", 64'(q1.size()), 64'(0));
    chk("sweep_w16_s2_drain", 64'(q2.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
